// File: rtl/cam_pattern_tx.sv
// OV7670-style camera source: generates PCLK/VSYNC/HREF/DATA frames of RGB444
// test patterns, two bytes per pixel, with all timing counted in PCLK periods.
module cam_pattern_tx #(
    parameter int WIDTH        = 176,
    parameter int HEIGHT       = 144,
    parameter int HBLANK       = 8,
    parameter int VSYNC_PCLKS  = 16,
    parameter int VBACK_LINES  = 2,
    parameter int VFRONT_LINES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        EN,
    input  logic [1:0]  MODE,
    input  logic [11:0] COLOR,
    output logic        PCLK,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  DATA,
    output logic        FRAME_DONE,
    output logic [7:0]  FRAME_CNT
);

    localparam int LINE_LEN = 2 * WIDTH + HBLANK;
    localparam int HMAX     = (LINE_LEN > VSYNC_PCLKS) ? LINE_LEN : VSYNC_PCLKS;
    localparam int HCW      = $clog2(HMAX);
    localparam int LMAX0    = (HEIGHT > VBACK_LINES) ? HEIGHT : VBACK_LINES;
    localparam int LMAX1    = (LMAX0 > VFRONT_LINES) ? LMAX0 : VFRONT_LINES;
    localparam int LMAX     = (LMAX1 > 2) ? LMAX1 : 2;
    localparam int LCW      = $clog2(LMAX);
    localparam int BAR_W    = (WIDTH >= 8) ? WIDTH / 8 : 1;

    localparam logic [HCW-1:0] LINE_LAST = HCW'(LINE_LEN - 1);
    localparam logic [HCW-1:0] VS_LAST   = HCW'(VSYNC_PCLKS - 1);
    localparam logic [HCW-1:0] ACT_LEN   = HCW'(2 * WIDTH);
    localparam logic [HCW-1:0] BAR_DIV   = HCW'(BAR_W);
    localparam logic [LCW-1:0] VB_LAST   = LCW'(VBACK_LINES - 1);
    localparam logic [LCW-1:0] ACT_LAST  = LCW'(HEIGHT - 1);
    localparam logic [LCW-1:0] VF_LAST   = LCW'(VFRONT_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t         state, nxt_state;
    logic [HCW-1:0] hcnt, nxt_hcnt;
    logic [LCW-1:0] lcnt, nxt_lcnt;
    logic           pclk_q;
    logic           frame_end;
    logic           entering_vsync;
    logic [1:0]     mode_q;
    logic [11:0]    color_q;

    logic [HCW-1:0] x_pix;
    logic [HCW-1:0] bar_raw;
    logic [2:0]     bar_idx;
    logic           x_b3, y_b3;
    logic [11:0]    pix;
    logic           nxt_href;
    logic [7:0]     nxt_data;

    // Everything except PCLK itself advances only on the CLK edge where PCLK falls.
    wire tick = pclk_q;

    // hcnt counts PCLK periods within VSYNC or within a line; lcnt counts lines.
    always_comb begin
        nxt_state = state;
        nxt_hcnt  = hcnt;
        nxt_lcnt  = lcnt;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (EN) begin
                    nxt_state = S_VSYNC;
                    nxt_hcnt  = '0;
                    nxt_lcnt  = '0;
                end
            end
            S_VSYNC: begin
                if (hcnt == VS_LAST) begin
                    nxt_state = S_VBACK;
                    nxt_hcnt  = '0;
                    nxt_lcnt  = '0;
                end else begin
                    nxt_hcnt = hcnt + HCW'(1);
                end
            end
            S_VBACK: begin
                if (hcnt == LINE_LAST) begin
                    nxt_hcnt = '0;
                    if (lcnt == VB_LAST) begin
                        nxt_state = S_ACTIVE;
                        nxt_lcnt  = '0;
                    end else begin
                        nxt_lcnt = lcnt + LCW'(1);
                    end
                end else begin
                    nxt_hcnt = hcnt + HCW'(1);
                end
            end
            S_ACTIVE: begin
                if (hcnt == LINE_LAST) begin
                    nxt_hcnt = '0;
                    if (lcnt == ACT_LAST) begin
                        nxt_state = S_VFRONT;
                        nxt_lcnt  = '0;
                    end else begin
                        nxt_lcnt = lcnt + LCW'(1);
                    end
                end else begin
                    nxt_hcnt = hcnt + HCW'(1);
                end
            end
            S_VFRONT: begin
                if (hcnt == LINE_LAST) begin
                    nxt_hcnt = '0;
                    if (lcnt == VF_LAST) begin
                        frame_end = 1'b1;
                        nxt_lcnt  = '0;
                        nxt_state = EN ? S_VSYNC : S_IDLE;
                    end else begin
                        nxt_lcnt = lcnt + LCW'(1);
                    end
                end else begin
                    nxt_hcnt = hcnt + HCW'(1);
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_hcnt  = '0;
                nxt_lcnt  = '0;
            end
        endcase
    end

    assign entering_vsync = (nxt_state == S_VSYNC) && (state != S_VSYNC);

    // Outputs are computed for the upcoming PCLK period and registered, so pins never glitch.
    always_comb begin
        x_pix   = nxt_hcnt >> 1;
        bar_raw = x_pix / BAR_DIV;
        bar_idx = (bar_raw > HCW'(7)) ? 3'd7 : 3'(bar_raw);
        x_b3    = |(x_pix & HCW'(8));
        y_b3    = |(nxt_lcnt & LCW'(8));
        pix     = 12'h000;
        case (mode_q)
            2'd0: pix = color_q;
            2'd1: pix = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
            2'd2: pix = {3{4'(x_pix >> 3)}};
            default: pix = (x_b3 ^ y_b3) ? 12'hFFF : 12'h000;
        endcase
        nxt_href = (nxt_state == S_ACTIVE) && (nxt_hcnt < ACT_LEN);
        nxt_data = 8'h00;
        if (nxt_href) begin
            nxt_data = nxt_hcnt[0] ? {4'h0, pix[11:8]} : pix[7:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pclk_q     <= 1'b0;
            state      <= S_IDLE;
            hcnt       <= '0;
            lcnt       <= '0;
            mode_q     <= 2'd0;
            color_q    <= 12'h000;
            VSYNC      <= 1'b0;
            HREF       <= 1'b0;
            DATA       <= 8'h00;
            FRAME_DONE <= 1'b0;
            FRAME_CNT  <= 8'h00;
        end else begin
            pclk_q     <= ~pclk_q;
            FRAME_DONE <= 1'b0;
            if (tick) begin
                state <= nxt_state;
                hcnt  <= nxt_hcnt;
                lcnt  <= nxt_lcnt;
                VSYNC <= (nxt_state == S_VSYNC);
                HREF  <= nxt_href;
                DATA  <= nxt_data;
                if (entering_vsync) begin
                    mode_q  <= MODE;
                    color_q <= COLOR;
                end
                if (frame_end) begin
                    FRAME_DONE <= 1'b1;
                    FRAME_CNT  <= FRAME_CNT + 8'd1;
                end
            end
        end
    end

    assign PCLK = pclk_q;

endmodule
